feature_compare_scheduler: RTL and testbench

//  Shares one signed multiplier and comparator among six EEG feature channels
//  (LL, NE, PS, theta, alpha, beta). Each channel's out/base pair is captured on its valid pulse.

---
 rtl/feature_compare_scheduler.sv | 141 ++++++++++++++
 tb/tb_feature_compare_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_compare_scheduler.sv
// Round-robin scheduler sharing one signed multiplier and comparator among six
// EEG feature channels; each served channel produces a registered out >= base*scale flag.
module feature_compare_scheduler #(
    parameter int                    W_OUT  = 72,
    parameter int                    W_BASE = 50,
    parameter int                    W_S    = 8,
    parameter logic signed [W_S-1:0] S0     = W_S'(1),
    parameter logic signed [W_S-1:0] S1     = W_S'(1),
    parameter logic signed [W_S-1:0] S2     = W_S'(1),
    parameter logic signed [W_S-1:0] S3     = W_S'(1),
    parameter logic signed [W_S-1:0] S4     = W_S'(1),
    parameter logic signed [W_S-1:0] S5     = W_S'(1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6*W_OUT-1:0]    feat_out,
    input  logic [6*W_BASE-1:0]   feat_base,
    input  logic [5:0]            feat_valid,
    input  logic                  clear_err,
    output logic [5:0]            feat_binary,
    output logic [5:0]            bin_valid,
    output logic                  busy,
    output logic [5:0]            drop_err
);

    localparam int W_P = W_BASE + W_S;
    localparam int W_C = ((W_OUT > W_P) ? W_OUT : W_P) + 1;

    logic [W_OUT-1:0]  holdOut_q  [6];
    logic [W_BASE-1:0] holdBase_q [6];

    logic [5:0]     pending_q, pending_d;
    logic [2:0]     rrPtr_q, rrPtr_d;
    logic [5:0]     dropErr_q, dropErr_d;
    logic           s1Valid_q;
    logic [W_P-1:0] s1Prod_q, s1Prod_d;
    logic [W_OUT-1:0] s1Op_q;
    logic [2:0]     s1Tag_q;
    logic [5:0]     featBinary_q, featBinary_d;
    logic [5:0]     binValid_q, binValid_d;

    logic           gntValid;
    logic [2:0]     gntCh;
    logic [5:0]     gntMask;
    logic [3:0]     cand;
    logic [W_BASE-1:0] opBase;
    logic [W_S-1:0]    opScale;
    logic [W_C-1:0]    cmpOp, cmpProd;

    function automatic logic [W_S-1:0] scaleOf(input logic [2:0] ch);
        case (ch)
            3'd0:    scaleOf = S0;
            3'd1:    scaleOf = S1;
            3'd2:    scaleOf = S2;
            3'd3:    scaleOf = S3;
            3'd4:    scaleOf = S4;
            default: scaleOf = S5;
        endcase
    endfunction

    for (genvar i = 0; i < 6; i++) begin : gHold
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                holdOut_q[i]  <= '0;
                holdBase_q[i] <= '0;
            end else if (feat_valid[i]) begin
                holdOut_q[i]  <= feat_out[i*W_OUT +: W_OUT];
                holdBase_q[i] <= feat_base[i*W_BASE +: W_BASE];
            end
        end
    end

    // Search starts one past the last granted channel so every pending channel is served within six cycles.
    always_comb begin
        gntValid = 1'b0;
        gntCh    = 3'd0;
        cand     = 4'd0;
        for (int k = 1; k <= 6; k++) begin
            cand = {1'b0, rrPtr_q} + 4'(k);
            if (cand >= 4'd6) cand = cand - 4'd6;
            if (!gntValid && pending_q[cand[2:0]]) begin
                gntValid = 1'b1;
                gntCh    = cand[2:0];
            end
        end
    end

    // A channel granted in the same cycle it is recaptured keeps pending and reports no drop.
    always_comb begin
        gntMask    = gntValid ? (6'b000001 << gntCh) : 6'b000000;
        pending_d  = (pending_q & ~gntMask) | feat_valid;
        dropErr_d  = (clear_err ? 6'b000000 : dropErr_q) | (feat_valid & pending_q & ~gntMask);
        rrPtr_d    = gntValid ? gntCh : rrPtr_q;

        opBase     = holdBase_q[gntCh];
        opScale    = scaleOf(gntCh);
        s1Prod_d   = $signed({{W_S{opBase[W_BASE-1]}}, opBase}) *
                     $signed({{W_BASE{opScale[W_S-1]}}, opScale});

        cmpOp      = {{(W_C-W_OUT){s1Op_q[W_OUT-1]}}, s1Op_q};
        cmpProd    = {{(W_C-W_P){s1Prod_q[W_P-1]}}, s1Prod_q};
        featBinary_d = featBinary_q;
        binValid_d   = 6'b000000;
        if (s1Valid_q) begin
            featBinary_d[s1Tag_q] = ($signed(cmpOp) >= $signed(cmpProd));
            binValid_d            = 6'b000001 << s1Tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= '0;
            rrPtr_q      <= 3'd5;
            dropErr_q    <= '0;
            s1Valid_q    <= 1'b0;
            s1Prod_q     <= '0;
            s1Op_q       <= '0;
            s1Tag_q      <= 3'd0;
            featBinary_q <= '0;
            binValid_q   <= '0;
        end else begin
            pending_q    <= pending_d;
            rrPtr_q      <= rrPtr_d;
            dropErr_q    <= dropErr_d;
            s1Valid_q    <= gntValid;
            if (gntValid) begin
                s1Prod_q <= s1Prod_d;
                s1Op_q   <= holdOut_q[gntCh];
                s1Tag_q  <= gntCh;
            end
            featBinary_q <= featBinary_d;
            binValid_q   <= binValid_d;
        end
    end

    assign feat_binary = featBinary_q;
    assign bin_valid   = binValid_q;
    assign drop_err    = dropErr_q;
    assign busy        = (|pending_q) | s1Valid_q | (|binValid_q);

endmodule

// File: tb/tb_feature_compare_scheduler.sv
// Bench for feature_compare_scheduler: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level reference model.
module tb_feature_compare_scheduler;

   localparam int W_OUT  = 72;
   localparam int W_BASE = 50;
   localparam int W_S    = 8;
   localparam int SC [6] = '{-2, 1, 3, 1, 1, -128};

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b1;
   logic [6*W_OUT-1:0]    feat_out = '0;
   logic [6*W_BASE-1:0]   feat_base = '0;
   logic [5:0]            feat_valid = '0;
   logic                  clear_err = 1'b0;
   logic [5:0]            feat_binary;
   logic [5:0]            bin_valid;
   logic                  busy;
   logic [5:0]            drop_err;

   feature_compare_scheduler #(
      .W_OUT(W_OUT), .W_BASE(W_BASE), .W_S(W_S),
      .S0(8'shFE), .S1(8'sh01), .S2(8'sh03), .S3(8'sh01), .S4(8'sh01), .S5(8'sh80)
   ) dut (
      .clk(clk), .rst_n(rst_n), .feat_out(feat_out), .feat_base(feat_base),
      .feat_valid(feat_valid), .clear_err(clear_err), .feat_binary(feat_binary),
      .bin_valid(bin_valid), .busy(busy), .drop_err(drop_err)
   );

   always #5 clk = ~clk;

   // Reference model state: captured values, pending set, last grant, and results in flight.
   typedef struct {
      int due;
      int ch;
      bit res;
   } result_t;

   logic signed [W_OUT-1:0]  mOut  [6];
   logic signed [W_BASE-1:0] mBase [6];
   logic [5:0]  mPend, mBin, mErr, expBv;
   int          mRr, cyc;
   bit          expBusy;
   result_t     inFlight [$];

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   function automatic bit refResult(input int ch);
      logic signed [127:0] o, p;
      o = mOut[ch];
      p = mBase[ch];
      p = p * SC[ch];
      return (o >= p);
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 6; i++) begin
         mOut[i]  = '0;
         mBase[i] = '0;
      end
      mPend = '0; mBin = '0; mErr = '0; expBv = '0;
      mRr = 5; expBusy = 1'b0;
      inFlight.delete();
   endtask

   // One clock edge of the specified behaviour, using the inputs the DUT just sampled.
   task automatic modelEdge(input logic [5:0] v, input logic clr);
      bit gv;
      int g, c;
      logic [5:0] gm, drop;
      cyc++;
      gv = 0; g = 0;
      for (int k = 1; k <= 6; k++) begin
         c = (mRr + k) % 6;
         if (!gv && mPend[c]) begin
            gv = 1; g = c;
         end
      end
      gm = '0;
      if (gv) begin
         gm[g] = 1'b1;
         inFlight.push_back('{due: cyc + 1, ch: g, res: refResult(g)});
         mRr = g;
      end
      drop  = v & mPend & ~gm;
      mErr  = (clr ? 6'b0 : mErr) | drop;
      mPend = (mPend & ~gm) | v;
      for (int i = 0; i < 6; i++) begin
         if (v[i]) begin
            mOut[i]  = feat_out[i*W_OUT +: W_OUT];
            mBase[i] = feat_base[i*W_BASE +: W_BASE];
         end
      end
      while (inFlight.size() > 0 && inFlight[0].due < cyc) void'(inFlight.pop_front());
      expBv = '0;
      foreach (inFlight[j]) begin
         if (inFlight[j].due == cyc) begin
            expBv[inFlight[j].ch] = 1'b1;
            mBin[inFlight[j].ch]  = inFlight[j].res;
         end
      end
      expBusy = (|mPend) || (inFlight.size() > 0);
   endtask

   task automatic checkOutput(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".bin_valid"}, bin_valid, expBv);
      checkOutput({tag, ".feat_binary"}, feat_binary, mBin);
      checkOutput({tag, ".drop_err"}, drop_err, mErr);
      checkOutput({tag, ".busy"}, {5'b0, busy}, {5'b0, expBusy});
   endtask

   // Called at posedge+1; presents inputs for one edge, then checks at the next posedge+1.
   task automatic applyStimulus(input logic [5:0] v, input logic clr, input string tag);
      feat_valid = v;
      clear_err  = clr;
      @(posedge clk);
      modelEdge(v, clr);
      #1;
      feat_valid = '0;
      clear_err  = 1'b0;
      checkAll(tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) applyStimulus(6'b0, 1'b0, tag);
   endtask

   task automatic doReset(input int n);
      rst_n = 1'b0;
      modelReset();
      #1;
      checkAll("reset");
      repeat (n) @(posedge clk);
      #1;
      checkAll("reset_hold");
      rst_n = 1'b1;
   endtask

   task automatic setSlot(input int ch, input logic signed [W_OUT-1:0] o,
                          input logic signed [W_BASE-1:0] b);
      feat_out[ch*W_OUT +: W_OUT]    = o;
      feat_base[ch*W_BASE +: W_BASE] = b;
   endtask

   // Random values, mostly placed near the decision threshold so both outcomes occur.
   task automatic randSlot(input int ch);
      logic signed [W_BASE-1:0] b;
      logic signed [127:0]      p;
      int t, d;
      case ($urandom_range(3))
         0: begin t = int'($urandom_range(2000)) - 1000; b = t; end
         1: b = W_BASE'({$urandom(), $urandom()});
         2: b = $urandom_range(1) ? {1'b1, {(W_BASE-1){1'b0}}} : {1'b0, {(W_BASE-1){1'b1}}};
         default: begin t = int'($urandom()); b = t; end
      endcase
      p = b;
      p = p * SC[ch];
      d = int'($urandom_range(4)) - 2;
      if ($urandom_range(7) == 0) setSlot(ch, W_OUT'({$urandom(), $urandom(), $urandom()}), b);
      else setSlot(ch, W_OUT'(p + d), b);
   endtask

   initial begin
      logic signed [W_OUT-1:0] big;
      logic [5:0] v;
      modelReset();
      cyc = 0;

      // Reset and quiet release
      #2;
      doReset(3);
      idle(3, "post_reset");

      // Single channel, scale 3: 300 >= 300, then 299 < 300
      setSlot(2, 72'sd300, 50'sd100);
      applyStimulus(6'b000100, 1'b0, "single_hi");
      idle(3, "single_hi");
      setSlot(2, 72'sd299, 50'sd100);
      applyStimulus(6'b000100, 1'b0, "single_lo");
      idle(3, "single_lo");

      // Signed, scale -2: -5 >= -6, then -7 < -6
      setSlot(0, -72'sd5, 50'sd3);
      applyStimulus(6'b000001, 1'b0, "signed_hi");
      idle(3, "signed_hi");
      setSlot(0, -72'sd7, 50'sd3);
      applyStimulus(6'b000001, 1'b0, "signed_lo");
      idle(3, "signed_lo");

      // Extremes, scale -128: -(2^49) * -128 = 2^56
      big = 72'sd1 <<< 56;
      setSlot(5, big, {1'b1, 49'b0});
      applyStimulus(6'b100000, 1'b0, "extreme_eq");
      idle(3, "extreme_eq");
      setSlot(5, big - 72'sd1, {1'b1, 49'b0});
      applyStimulus(6'b100000, 1'b0, "extreme_lt");
      idle(3, "extreme_lt");

      // All six at once: back-to-back grants
      for (int i = 0; i < 6; i++) randSlot(i);
      applyStimulus(6'b111111, 1'b0, "round_robin");
      idle(9, "round_robin");

      // Drop on ch4 while ch0..3 pending; second capture must win
      for (int i = 0; i < 5; i++) randSlot(i);
      applyStimulus(6'b011111, 1'b0, "drop_first");
      randSlot(4);
      applyStimulus(6'b010000, 1'b0, "drop_second");
      idle(8, "drop_drain");
      applyStimulus(6'b000000, 1'b1, "clear_err");
      idle(1, "after_clear");

      // Collision: ch1 recaptured on its grant cycle
      randSlot(1);
      applyStimulus(6'b000010, 1'b0, "collide_a");
      randSlot(1);
      applyStimulus(6'b000010, 1'b0, "collide_b");
      idle(5, "collide_drain");

      // Reset while a result is in the pipeline
      setSlot(1, 72'sd10, 50'sd1);
      applyStimulus(6'b000010, 1'b0, "mid_reset_cap");
      applyStimulus(6'b000000, 1'b0, "mid_reset_grant");
      doReset(2);
      idle(5, "after_mid_reset");

      // Random traffic with occasional error clears
      for (int n = 0; n < 400; n++) begin
         v = 6'($urandom()) & 6'($urandom());
         for (int i = 0; i < 6; i++) if (v[i]) randSlot(i);
         applyStimulus(v, ($urandom_range(15) == 0), "random");
      end
      idle(10, "random_drain");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
